// File: rtl/fifo_pkg.sv
// Shared definitions for the async_fifo read-side drain path.
package fifo_pkg;

  localparam int DATA_W     = 8;
  localparam int SKID_DEPTH = 2;

  typedef logic [DATA_W-1:0] fifo_data_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry register buffer; head is always entry 0, tolerates push and pop in the same cycle.
module stream_skid2
  import fifo_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  localparam int OCC_W = $clog2(SKID_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head_data
);

  logic [OCC_W-1:0] occ_q, occ_d, occ_after_pop;
  logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic             pop_eff, push_eff;

  always_comb begin
    pop_eff       = pop && (occ_q != '0);
    occ_after_pop = occ_q - OCC_W'(pop_eff);
    push_eff      = push && (occ_after_pop < OCC_W'(SKID_DEPTH));
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    occ_d         = occ_after_pop + OCC_W'(push_eff);
    // Shift first so the push lands in the first slot left free by the pop.
    if (pop_eff) begin
      ent0_d = ent1_q;
    end
    if (push_eff) begin
      if (occ_after_pop == '0) begin
        ent0_d = push_data;
      end else begin
        ent1_d = push_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= '0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = ent0_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side drain stage: issues FIFO reads on credit, absorbs the 1-cycle read latency,
// re-presents words as a valid/ready stream and counts FIFO read errors.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_rd_error,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic [ERR_CNT_W-1:0] rd_err_cnt
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  logic [OCC_W-1:0]     occ;
  logic                 inflight_q;
  logic                 pop;
  logic [OCC_W:0]       credit_used;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  stream_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (rd_clk),
    .rst       (reset),
    .push      (inflight_q),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  // Count the in-flight word against the buffer so it always has a slot when it lands.
  always_comb begin
    credit_used = {1'b0, occ} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);
    fifo_rd_en  = enable && !fifo_empty && !reset && (credit_used < (OCC_W + 1)'(SKID_DEPTH));
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (fifo_rd_error && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rd_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: behavioural 1-cycle-latency FIFO, vector table plus directed sequences.
module tb_fifo_rd_streamer;

  logic       rd_clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd_error;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [7:0] rd_err_cnt;

  fifo_rd_streamer #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .rd_clk        (rd_clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_rd_error (fifo_rd_error),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .rd_err_cnt    (rd_err_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: registered rdata one cycle after rd_en is sampled
  logic [7:0] mem [1024];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rdata <= mem[rd_ptr % 1024];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int cyc = 0, rd_cnt = 0, viol = 0, vcyc = 0, first_v = -1, last_v = -1;

  always @(negedge rd_clk) begin
    cyc++;
    if (fifo_rd_en) rd_cnt++;
    if (fifo_rd_en && fifo_empty) viol++;
    if (m_valid) begin
      vcyc++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (m_valid && m_ready) got.push_back(m_data);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  function automatic int order_errors();
    int e = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (i >= exp_q.size() || got[i] !== exp_q[i]) e++;
    end
    return e;
  endfunction

  task automatic clear_mon();
    got.delete();
    exp_q.delete();
    rd_cnt = 0; viol = 0; vcyc = 0; first_v = -1; last_v = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    fifo_rd_error = 1'b0;
    flush = 1'b1;
    repeat (2) @(posedge rd_clk);
    #1;
    flush = 1'b0;
    reset = 1'b0;
    clear_mon();
  endtask

  typedef struct {
    logic       en;
    logic       rdy;
    logic       push;
    logic [7:0] pdata;
    logic       exp_rd_en;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int budget;
    int r0;
    int bad;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA2};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 8'hA3};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};

    do_reset();
    check("reset_m_valid", m_valid, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_m_data", m_data, 0);
    check("reset_err_cnt", rd_err_cnt, 0);

    // Vector table: one row per cycle, inputs driven after posedge, outputs checked at negedge
    for (int i = 0; i < 14; i++) begin
      enable  = vecs[i].en;
      m_ready = vecs[i].rdy;
      if (vecs[i].push) push_word(vecs[i].pdata);
      @(negedge rd_clk);
      check($sformatf("vec%0d_rd_en", i), fifo_rd_en, vecs[i].exp_rd_en);
      check($sformatf("vec%0d_valid", i), m_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), m_data, vecs[i].exp_data);
      @(posedge rd_clk);
      #1;
    end

    // Drain of 16 preloaded words at full throughput
    do_reset();
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (25) @(posedge rd_clk);
    #1;
    check("drain_count", got.size(), 16);
    check("drain_order", order_errors(), 0);
    check("drain_rd_en_cnt", rd_cnt, 16);
    check("drain_valid_cycles", vcyc, 16);
    check("drain_contiguous", last_v - first_v + 1, 16);
    check("drain_valid_end", m_valid, 0);

    // Backpressure after word 3
    do_reset();
    for (int i = 0; i < 20; i++) push_word(8'(8'h21 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    budget = 0;
    while (got.size() < 3 && budget < 50) begin
      @(posedge rd_clk);
      #1;
      budget++;
    end
    m_ready = 1'b0;
    check("bp_accepted", got.size(), 3);
    bad = 0;
    repeat (10) begin
      @(negedge rd_clk);
      if (!m_valid || m_data !== 8'h24) bad++;
    end
    check("bp_hold_stable", bad, 0);
    check("bp_pulled", rd_cnt, 5);
    @(posedge rd_clk);
    #1;
    m_ready = 1'b1;
    repeat (30) @(posedge rd_clk);
    #1;
    check("bp_total", got.size(), 20);
    check("bp_order", order_errors(), 0);

    // Random m_ready over 200 words
    do_reset();
    for (int i = 0; i < 200; i++) push_word(8'((i * 7 + 3) & 8'hff));
    enable = 1'b1;
    budget = 0;
    while (got.size() < 200 && budget < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge rd_clk);
      #1;
      budget++;
    end
    m_ready = 1'b1;
    repeat (5) @(posedge rd_clk);
    #1;
    check("rand_count", got.size(), 200);
    check("rand_order", order_errors(), 0);
    check("rand_rd_en_empty", viol, 0);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 16; i++) push_word(8'(8'h50 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    fifo_rd_error = 1'b1;
    repeat (2) @(posedge rd_clk);
    #1;
    fifo_rd_error = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    check("rst_pre_valid", m_valid, 1);
    check("rst_pre_err", rd_err_cnt, 2);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_rd_en", fifo_rd_en, 0);
    check("rst_mid_data", m_data, 0);
    check("rst_mid_err", rd_err_cnt, 0);

    // enable 1->0 while rd_en active
    do_reset();
    for (int i = 0; i < 10; i++) push_word(8'(8'h90 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1;
    check("en_drop_rd_en_active", fifo_rd_en, 1);
    r0 = rd_cnt;
    @(posedge rd_clk);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge rd_clk);
    #1;
    check("en_drop_rd_cnt", rd_cnt, r0 + 1);
    check("en_drop_words", got.size(), r0 + 1);
    check("en_drop_order", order_errors(), 0);
    check("en_drop_idle_valid", m_valid, 0);

    // Error counter saturation
    do_reset();
    fifo_rd_error = 1'b1;
    repeat (100) @(posedge rd_clk);
    #1;
    check("err_cnt_100", rd_err_cnt, 100);
    repeat (200) @(posedge rd_clk);
    #1;
    check("err_cnt_sat", rd_err_cnt, 255);
    repeat (5) @(posedge rd_clk);
    #1;
    check("err_cnt_hold", rd_err_cnt, 255);
    fifo_rd_error = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
